// File: rtl/hdr_pkg.sv
// hdr_pkg -- shared definitions for the HDR frame sequencer.
//   State encoding, bus mode codes, engine index of the CCC engine and the
//   default register-file special addresses.
package hdr_pkg;

  typedef logic [2:0] hdr_state_t;

  localparam hdr_state_t S_IDLE  = 3'd0;
  localparam hdr_state_t S_CCC   = 3'd1;
  localparam hdr_state_t S_DUMMY = 3'd2;
  localparam hdr_state_t S_XFER  = 3'd3;
  localparam hdr_state_t S_EXIT  = 3'd4;
  localparam hdr_state_t S_ABORT = 3'd5;

  localparam logic [2:0] HDR_MODE_DDR = 3'd6;

  localparam int ENG_CCC = 0;

  localparam int DEFAULT_SPECIAL_ADDR = 10;
  localparam int DUMMY_SPECIAL_ADDR   = 9;

endpackage

// File: rtl/hdr_seq_watchdog.sv
// hdr_seq_watchdog -- per-activation cycle counter for the HDR sequencer.
//   i_sys_clk / i_sys_rst_n : clock, async active-low reset
//   i_clear                 : restart count from zero (wins over i_run)
//   i_run                   : count this cycle
//   o_expire                : running and count reached TIMEOUT_CYC-1
module hdr_seq_watchdog #(
  parameter int TIMEOUT_CYC = 1024,
  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  logic [W-1:0] cnt;

  assign o_expire = i_run && (cnt == W'(TIMEOUT_CYC - 1));

  // Hold at the limit so the count never wraps while the owner reacts.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n)            cnt <= '0;
    else if (i_clear)            cnt <= '0;
    else if (i_run && !o_expire) cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/hdr_sequencer.sv
// hdr_sequencer -- sequences the HDR frames of one controller transaction.
//   Dispatches each frame to the CCC engine (index 0) or a transfer engine,
//   inserts the dummy-word fetch after a CCC followed by a normal frame,
//   follows restart/exit per frame, counts frames, and (optionally) aborts
//   a hung engine.
// Build option: define HDR_SEQ_WATCHDOG_EN to include the activation watchdog;
//   without it ABORT is unreachable and o_error stays 0.
// Ports:
//   i_sys_clk, i_sys_rst_n : clock, async active-low reset
//   i_hdr_en    : sequencer enable (level)      i_mode     : current bus mode
//   i_cp        : next frame is CCC             i_toc      : exit after frame
//   i_xfer_sel  : transfer engine select        i_eng_done : per-engine done
//   o_eng_en    : one-hot engine enable         o_regf_addr: special address
//   o_done      : finish/abort pulse            o_error    : sticky abort flag
//   o_frame_cnt : completed frames, saturating
module hdr_sequencer
  import hdr_pkg::*;
#(
  parameter int               NUM_ENG      = 3,
  parameter int               SEL_W        = $clog2(NUM_ENG),
  parameter int               ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] DEFAULT_ADDR = ADDR_W'(DEFAULT_SPECIAL_ADDR),
  parameter logic [ADDR_W-1:0] DUMMY_ADDR   = ADDR_W'(DUMMY_SPECIAL_ADDR),
  parameter logic [2:0]       HDR_MODE     = HDR_MODE_DDR,
  parameter int               CNT_W        = 4,
  parameter int               TIMEOUT_CYC  = 1024
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst_n,
  input  logic               i_hdr_en,
  input  logic [2:0]         i_mode,
  input  logic               i_cp,
  input  logic               i_toc,
  input  logic [SEL_W-1:0]   i_xfer_sel,
  input  logic [NUM_ENG-1:0] i_eng_done,
  output logic [NUM_ENG-1:0] o_eng_en,
  output logic [ADDR_W-1:0]  o_regf_addr,
  output logic               o_done,
  output logic               o_error,
  output logic [CNT_W-1:0]   o_frame_cnt
);

  if (NUM_ENG < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("hdr_sequencer: NUM_ENG and TIMEOUT_CYC must be at least 2");
  end

  hdr_state_t         state;
  logic               armed;    // cleared on finish; re-armed by i_hdr_en low in IDLE
  logic               launch;   // in the one-cycle gap before the next engine starts
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   eff_sel;
  logic [NUM_ENG-1:0] ccc_oh;
  logic               busy, comp, counted, mode_ok, wdg_expire;

  assign busy    = (state == S_CCC) || (state == S_DUMMY) || (state == S_XFER);
  // o_eng_en is zero during gaps, so stray done pulses there are ignored too.
  assign comp    = busy && |(i_eng_done & o_eng_en);
  assign counted = comp && (state != S_DUMMY);
  assign mode_ok = (i_mode == HDR_MODE);
  assign ccc_oh  = NUM_ENG'(1) << ENG_CCC;
  // Select 0 is the CCC engine and out-of-range values are invalid: both go to DDR.
  assign eff_sel = (i_xfer_sel == '0 || 32'(i_xfer_sel) >= 32'(NUM_ENG))
                 ? SEL_W'(1) : i_xfer_sel;

`ifdef HDR_SEQ_WATCHDOG_EN
  hdr_seq_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdg (
    .i_sys_clk   (i_sys_clk),
    .i_sys_rst_n (i_sys_rst_n),
    .i_clear     (!busy || comp),
    .i_run       (busy),
    .o_expire    (wdg_expire)
  );
`else
  assign wdg_expire = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state       <= S_IDLE;
      o_eng_en    <= '0;
      o_regf_addr <= DEFAULT_ADDR;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_frame_cnt <= '0;
      armed       <= 1'b1;
      launch      <= 1'b0;
      sel_q       <= SEL_W'(1);
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!i_hdr_en) armed <= 1'b1;
          else if (armed) begin
            if (mode_ok) begin
              o_error     <= 1'b0;
              o_frame_cnt <= '0;
              sel_q       <= eff_sel;
              if (i_cp) begin
                state    <= S_CCC;
                o_eng_en <= ccc_oh;
              end else begin
                state    <= S_XFER;
                o_eng_en <= NUM_ENG'(1) << eff_sel;
              end
            end else begin
              state  <= S_EXIT;
              o_done <= 1'b1;
            end
          end
        end
        S_EXIT, S_ABORT: begin
          state <= S_IDLE;
          armed <= 1'b0;
        end
        default: begin
          if (!i_hdr_en) begin
            // Silent cancel: no done pulse, error flag untouched.
            state       <= S_IDLE;
            o_eng_en    <= '0;
            o_regf_addr <= DEFAULT_ADDR;
            launch      <= 1'b0;
          end else begin
            if (counted && o_frame_cnt != '1) o_frame_cnt <= o_frame_cnt + CNT_W'(1);
            if (!mode_ok) begin
              state       <= S_EXIT;
              o_done      <= 1'b1;
              o_eng_en    <= '0;
              o_regf_addr <= DEFAULT_ADDR;
              launch      <= 1'b0;
            end else if (comp) begin
              o_eng_en    <= '0;
              o_regf_addr <= DEFAULT_ADDR;
              sel_q       <= eff_sel;
              launch      <= 1'b1;
              if (state == S_DUMMY) state <= S_XFER;
              else if (i_toc) begin
                state  <= S_EXIT;
                o_done <= 1'b1;
                launch <= 1'b0;
              end else if (i_cp) state <= S_CCC;
              else if (state == S_CCC) begin
                state       <= S_DUMMY;
                o_regf_addr <= DUMMY_ADDR;
              end else state <= S_XFER;
            end else if (wdg_expire) begin
              state       <= S_ABORT;
              o_done      <= 1'b1;
              o_error     <= 1'b1;
              o_eng_en    <= '0;
              o_regf_addr <= DEFAULT_ADDR;
              launch      <= 1'b0;
            end else if (launch) begin
              launch   <= 1'b0;
              o_eng_en <= (state == S_XFER) ? (NUM_ENG'(1) << sel_q) : ccc_oh;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_sequencer.sv
module tb_hdr_sequencer;
  localparam int NUM_ENG = 3, SEL_W = 2, ADDR_W = 8, CNT_W = 4, TIMEOUT_CYC = 16;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               hdr_en = 1'b0, cp = 1'b0, toc = 1'b0;
  logic [2:0]         mode = 3'd6;
  logic [SEL_W-1:0]   sel = '0;
  logic [NUM_ENG-1:0] edone = '0;
  logic [NUM_ENG-1:0] eng_en;
  logic [ADDR_W-1:0]  regf;
  logic               done, err;
  logic [CNT_W-1:0]   cnt;

  int n_chk = 0, n_err = 0;
  int c[20], s[20];

  always #5 clk = ~clk;

  hdr_sequencer #(.NUM_ENG(NUM_ENG), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
                  .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_hdr_en(hdr_en), .i_mode(mode),
    .i_cp(cp), .i_toc(toc), .i_xfer_sel(sel), .i_eng_done(edone),
    .o_eng_en(eng_en), .o_regf_addr(regf), .o_done(done), .o_error(err),
    .o_frame_cnt(cnt));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference rules: select 0 or out-of-range goes to DDR (engine 1).
  function automatic int eff(int v);
    return (v == 0 || v >= NUM_ENG) ? 1 : v;
  endfunction

  function automatic int sat(int n);
    return (n > 15) ? 15 : n;
  endfunction

  function automatic void fill_rand(int n);
    for (int i = 0; i < n; i++) begin
      c[i] = $urandom_range(0, 1);
      s[i] = $urandom_range(0, 3);
    end
  endfunction

  // Plays one sequence of n frames described by c[]/s[]; last frame exits.
  task automatic run_seq(input int n);
    int exp, d;
    hdr_en = 1'b0; cyc();
    hdr_en = 1'b1; mode = 3'd6; cp = c[0][0]; sel = SEL_W'(s[0]); toc = 1'b0;
    cyc();
    for (int i = 0; i < n; i++) begin
      exp = c[i] ? 1 : (1 << eff(s[i]));
      d = $urandom_range(0, 4);
      repeat (d) begin
        check("eng_en_busy", eng_en, exp);
        edone = NUM_ENG'($urandom) & ~NUM_ENG'(exp);
        cyc(); edone = '0;
      end
      check("eng_en_on", eng_en, exp);
      check("regf_frame", regf, 10);
      edone = NUM_ENG'(exp); toc = (i == n - 1);
      if (i < n - 1) begin cp = c[i+1][0]; sel = SEL_W'(s[i+1]); end
      else begin cp = 1'($urandom); sel = SEL_W'($urandom); end
      cyc(); edone = '0; toc = 1'b0;
      check("frame_cnt", cnt, sat(i + 1));
      check("eng_en_gap", eng_en, 0);
      if (i == n - 1) begin
        check("done_pulse", done, 1);
        cyc(); check("done_low", done, 0);
        cyc(); check("no_restart", eng_en, 0); check("no_restart_done", done, 0);
        return;
      end
      check("no_done_mid", done, 0);
      if (c[i] != 0 && c[i+1] == 0) begin
        cyc();
        d = $urandom_range(0, 3);
        repeat (d) begin
          check("dummy_en", eng_en, 1); check("dummy_addr", regf, 9);
          cyc();
        end
        check("dummy_en", eng_en, 1); check("dummy_addr", regf, 9);
        edone = 3'b001; cyc(); edone = '0;
        check("dummy_gap", eng_en, 0); check("dummy_gap_addr", regf, 10);
        check("dummy_not_counted", cnt, sat(i + 1));
      end
      cyc();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (n_err=%0d)", n_err);
    $fatal(1);
  end

  initial begin
    repeat (2) cyc();
    check("rst_eng_en", eng_en, 0);
    check("rst_regf", regf, 10);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    check("rst_cnt", cnt, 0);
    rst_n = 1'b1; cyc();

    // Single DDR frame with exit.
    c[0] = 0; s[0] = 1; run_seq(1);
    // CCC, dummy fetch, then DDR frame with exit.
    c[0] = 1; s[0] = 0; c[1] = 0; s[1] = 1; run_seq(2);
    // Long restart chain: counter saturates.
    fill_rand(20); run_seq(20);
    repeat (25) begin
      int n;
      n = $urandom_range(1, 8);
      fill_rand(n); run_seq(n);
    end

    // Mode leaves HDR mid-transfer.
    hdr_en = 1'b0; cyc();
    hdr_en = 1'b1; cp = 1'b0; sel = 2'd2; cyc();
    check("md_en", eng_en, 4); cyc();
    mode = 3'd0; cyc(); mode = 3'd6;
    check("md_drop_en", eng_en, 0); check("md_done", done, 1); check("md_err", err, 0);
    cyc(); check("md_done_low", done, 0);

    // Mode drop together with done: exit wins, frame still counted.
    hdr_en = 1'b0; cyc();
    hdr_en = 1'b1; cp = 1'b1; cyc();
    check("mdd_en", eng_en, 1); check("mdd_cnt0", cnt, 0);
    edone = 3'b001; mode = 3'd0; cyc(); edone = '0; mode = 3'd6;
    check("mdd_done", done, 1); check("mdd_cnt", cnt, 1); check("mdd_en_off", eng_en, 0);
    cyc();

    // Start attempt outside HDR mode: exit with no engine.
    hdr_en = 1'b0; cyc();
    mode = 3'd2; hdr_en = 1'b1; cyc(); mode = 3'd6;
    check("bad_mode_done", done, 1); check("bad_mode_en", eng_en, 0);
    cyc(); check("bad_mode_done_low", done, 0);
    cyc(); check("bad_mode_no_restart", eng_en, 0);

    // Enable dropped mid-CCC: silent return to idle, then fresh start.
    hdr_en = 1'b0; cyc();
    hdr_en = 1'b1; cp = 1'b1; cyc();
    check("drop_ccc_en", eng_en, 1); cyc();
    hdr_en = 1'b0; cyc();
    check("drop_en_off", eng_en, 0); check("drop_no_done", done, 0);
    cyc(); check("drop_no_done2", done, 0);
    hdr_en = 1'b1; cp = 1'b0; sel = 2'd3; cyc();
    check("toggle_restart_en", eng_en, 2);
    hdr_en = 1'b0; cyc(); cyc();
    check("toggle_cancel_en", eng_en, 0);

`ifdef HDR_SEQ_WATCHDOG_EN
    hdr_en = 1'b1; cp = 1'b0; sel = 2'd2; cyc();
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      check("wd_en_held", eng_en, 4); cyc();
    end
    check("wd_abort_en", eng_en, 0); check("wd_done", done, 1); check("wd_err", err, 1);
    cyc(); check("wd_done_low", done, 0); check("wd_err_sticky", err, 1);
    hdr_en = 1'b0; cyc();
    hdr_en = 1'b1; cp = 1'b0; sel = 2'd1; cyc();
    check("wd_err_cleared", err, 0);
    edone = 3'b010; toc = 1'b1; cyc(); edone = '0; toc = 1'b0;
    check("wd_restart_done", done, 1); check("wd_restart_err", err, 0);
    hdr_en = 1'b0; cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
